// File: rtl/fir_tap_sequencer.sv
// Control sequencer for a symmetric FIR filter. Each sample is shifted in, the MAC walks the tap pairs, the pipeline is drained, and then the result is flagged.
// Defining FIR_SEQ_OVERRUN_CNT_EN adds overrun_cnt, an 8-bit saturating count of dropped samples.
module fir_tap_sequencer #(
  parameter int NTAPS   = 102,
  parameter int MAC_LAT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  output logic                       shift_en,
  output logic [$clog2(NTAPS)-1:0]   tap_a,
  output logic [$clog2(NTAPS)-1:0]   tap_b,
  output logic [$clog2(NTAPS/2)-1:0] coef_addr,
  output logic                       acc_clr,
  output logic                       acc_en,
  output logic                       out_valid,
  output logic                       busy,
`ifdef FIR_SEQ_OVERRUN_CNT_EN
  output logic [7:0]                 overrun_cnt,
`endif
  output logic                       overrun
);

  localparam int AW   = $clog2(NTAPS);
  localparam int CW   = $clog2(NTAPS/2);
  localparam int HALF = NTAPS/2;

  localparam logic [CW-1:0] K_LAST   = CW'(HALF-1);
  localparam logic [AW-1:0] TAP_LAST = AW'(NTAPS-1);
  localparam logic [3:0]    F_LAST   = 4'(MAC_LAT-1);

  typedef enum logic [2:0] {IDLE, SHIFT, MAC, FLUSH, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [3:0]    fcnt_q, fcnt_d;

  logic          shift_en_q, shift_en_d;
  logic [AW-1:0] tap_a_q, tap_a_d;
  logic [AW-1:0] tap_b_q, tap_b_d;
  logic [CW-1:0] coef_addr_q, coef_addr_d;
  logic          acc_clr_q, acc_clr_d;
  logic          acc_en_q, acc_en_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  logic          in_mac;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE:  if (sample_valid) state_d = SHIFT;
      SHIFT: begin
        state_d = MAC;
        k_d     = '0;
      end
      MAC: begin
        if (k_q == K_LAST) begin
          state_d = FLUSH;
          k_d     = '0;
          fcnt_d  = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      FLUSH: begin
        if (fcnt_q == F_LAST) state_d = DONE;
        else                  fcnt_d  = fcnt_q + 1'b1;
      end
      DONE:    state_d = sample_valid ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state they describe.
  always_comb begin
    in_mac      = (state_d == MAC);
    shift_en_d  = (state_d == SHIFT);
    acc_en_d    = in_mac;
    acc_clr_d   = in_mac && (k_d == '0);
    tap_a_d     = in_mac ? AW'(k_d) : '0;
    tap_b_d     = in_mac ? (TAP_LAST - AW'(k_d)) : TAP_LAST;
    coef_addr_d = in_mac ? k_d : '0;
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    overrun_d   = sample_valid && (state_q inside {SHIFT, MAC, FLUSH});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      fcnt_q      <= '0;
      shift_en_q  <= 1'b0;
      tap_a_q     <= '0;
      tap_b_q     <= TAP_LAST;
      coef_addr_q <= '0;
      acc_clr_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      fcnt_q      <= fcnt_d;
      shift_en_q  <= shift_en_d;
      tap_a_q     <= tap_a_d;
      tap_b_q     <= tap_b_d;
      coef_addr_q <= coef_addr_d;
      acc_clr_q   <= acc_clr_d;
      acc_en_q    <= acc_en_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign shift_en  = shift_en_q;
  assign tap_a     = tap_a_q;
  assign tap_b     = tap_b_q;
  assign coef_addr = coef_addr_q;
  assign acc_clr   = acc_clr_q;
  assign acc_en    = acc_en_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

`ifdef FIR_SEQ_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt_q, overrun_cnt_d;

  always_comb begin
    overrun_cnt_d = overrun_cnt_q;
    if (overrun_d && (overrun_cnt_q != 8'hFF)) overrun_cnt_d = overrun_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun_cnt_q <= '0;
    else     overrun_cnt_q <= overrun_cnt_d;
  end

  assign overrun_cnt = overrun_cnt_q;
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer: a schedule model is checked every cycle, and a scoreboard holds the expected out_valid cycles.
`timescale 1ns/1ps
module tb_fir_tap_sequencer;
  localparam int NTAPS   = 102;
  localparam int MAC_LAT = 3;
  localparam int AW      = $clog2(NTAPS);
  localparam int CW      = $clog2(NTAPS/2);
  localparam int HALF    = NTAPS/2;
  localparam int TOTAL   = 2 + HALF + MAC_LAT;
  localparam int MAXC    = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_valid;
  logic          shift_en;
  logic [AW-1:0] tap_a;
  logic [AW-1:0] tap_b;
  logic [CW-1:0] coef_addr;
  logic          acc_clr;
  logic          acc_en;
  logic          out_valid;
  logic          busy;
  logic          overrun;
`ifdef FIR_SEQ_OVERRUN_CNT_EN
  logic [7:0]    overrun_cnt;
`endif

  always #5 clk = ~clk;

  fir_tap_sequencer #(.NTAPS(NTAPS), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .sample_valid(sample_valid),
    .shift_en(shift_en),
    .tap_a(tap_a),
    .tap_b(tap_b),
    .coef_addr(coef_addr),
    .acc_clr(acc_clr),
    .acc_en(acc_en),
    .out_valid(out_valid),
    .busy(busy),
`ifdef FIR_SEQ_OVERRUN_CNT_EN
    .overrun_cnt(overrun_cnt),
`endif
    .overrun(overrun)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic sv_tab [MAXC];
  logic rst_tab[MAXC];

  int start;
  bit exp_ov;
  int exp_cnt;
  int done_q[$];

  int first_shift, last_shift, first_clr, n_acc, first_out, last_out, n_out;
  int first_orun, n_orun, busy_fall;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic clear_tab();
    for (int i = 0; i < MAXC; i++) begin
      sv_tab[i]  = 1'b0;
      rst_tab[i] = 1'b0;
    end
    rst_tab[0] = 1'b1;
  endtask

  task automatic run_scenario(input int len);
    int d, k;
    bit e_rst, e_mac, e_busy, act;
    start = -1; exp_ov = 0;
    first_shift = -1; last_shift = -1; first_clr = -1; n_acc = 0;
    first_out = -1; last_out = -1; n_out = 0; first_orun = -1; n_orun = 0; busy_fall = -1;
    for (int n = 0; n < len; n++) begin
      @(posedge clk);
      #1;
      cyc = n;
      rst = rst_tab[n];
      sample_valid = sv_tab[n];
      @(negedge clk);
      e_rst  = rst;
      d      = (start >= 0) ? n - start : -1;
      k      = d - 2;
      e_mac  = !e_rst && d >= 2 && d <= 1 + HALF;
      e_busy = !e_rst && d >= 1 && d <= TOTAL;
      check("shift_en", shift_en, int'(!e_rst && d == 1));
      check("acc_en", acc_en, int'(e_mac));
      check("acc_clr", acc_clr, int'(e_mac && k == 0));
      check("tap_a", tap_a, e_mac ? k : 0);
      check("tap_b", tap_b, e_mac ? NTAPS - 1 - k : NTAPS - 1);
      check("coef_addr", coef_addr, e_mac ? k : 0);
      check("out_valid", out_valid, int'(!e_rst && d == TOTAL));
      check("busy", busy, int'(e_busy));
      check("overrun", overrun, int'(!e_rst && exp_ov));
`ifdef FIR_SEQ_OVERRUN_CNT_EN
      check("overrun_cnt", overrun_cnt, e_rst ? 0 : exp_cnt);
`endif
      if (shift_en) begin
        if (first_shift < 0) first_shift = n;
        last_shift = n;
      end
      if (acc_clr && first_clr < 0) first_clr = n;
      if (acc_en) n_acc++;
      if (overrun) begin
        if (first_orun < 0) first_orun = n;
        n_orun++;
      end
      if (n_out > 0 && !busy && busy_fall < 0) busy_fall = n;
      if (out_valid) begin
        if (first_out < 0) first_out = n;
        last_out = n;
        n_out++;
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else                    check("done_cycle", n, done_q.pop_front());
      end
      if (e_rst) begin
        start = -1; exp_ov = 0; exp_cnt = 0;
        done_q.delete();
      end else begin
        act    = start >= 0 && d >= 1 && d < TOTAL;
        exp_ov = sample_valid && act;
        if (exp_ov && exp_cnt < 255) exp_cnt++;
        if (sample_valid && !act) begin
          start = n;
          done_q.push_back(n + TOTAL);
        end else if (start >= 0 && d >= TOTAL) begin
          start = -1;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sample_valid = 1'b0;
    exp_cnt = 0;

    clear_tab(); sv_tab[10] = 1'b1;
    run_scenario(80);
    check("s1_shift", first_shift, 11);
    check("s1_clr", first_clr, 12);
    check("s1_acc_n", n_acc, 51);
    check("s1_out", first_out, 66);
    check("s1_out_n", n_out, 1);
    check("s1_busy_low", busy_fall, 67);
    check("s1_orun_n", n_orun, 0);

    clear_tab(); sv_tab[10] = 1'b1; sv_tab[40] = 1'b1;
    run_scenario(80);
    check("s2_orun", first_orun, 41);
    check("s2_orun_n", n_orun, 1);
    check("s2_out", first_out, 66);
    check("s2_out_n", n_out, 1);

    clear_tab(); sv_tab[10] = 1'b1; sv_tab[66] = 1'b1;
    run_scenario(130);
    check("s3_out", first_out, 66);
    check("s3_shift2", last_shift, 67);
    check("s3_out2", last_out, 122);
    check("s3_out_n", n_out, 2);
    check("s3_orun_n", n_orun, 0);

    clear_tab(); sv_tab[10] = 1'b1; rst_tab[30] = 1'b1; sv_tab[35] = 1'b1;
    run_scenario(100);
    check("s4_out", first_out, 91);
    check("s4_out_n", n_out, 1);

    clear_tab(); sv_tab[0] = 1'b1; sv_tab[1] = 1'b1;
    run_scenario(70);
    check("s5_shift", first_shift, 2);
    check("s5_out", first_out, 57);

    clear_tab();
    for (int i = 1; i < 400; i++) sv_tab[i] = 1'b1;
    run_scenario(410);
    check("s6_drops_ge300", int'(n_orun >= 300), 1);
    check("s6_out_n", n_out, 7);
`ifdef FIR_SEQ_OVERRUN_CNT_EN
    check("s6_cnt_sat", overrun_cnt, 255);
`endif

    clear_tab();
    run_scenario(5);
    check("s7_idle_busy", busy, 0);
`ifdef FIR_SEQ_OVERRUN_CNT_EN
    check("s7_cnt_clr", overrun_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
